// File: rtl/bit_index_serializer.sv
// -----------------------------------------------------------------------------
// bit_index_serializer
//
// Accepts a WIDTH-bit vector and emits one beat per set bit, most significant
// set bit first. Each beat carries the bit index on `location`; `last` marks
// the beat for the final set bit. A vector is taken only while the block is
// idle, so consecutive vectors are separated by one dead cycle.
//
// Optional feature (macro BIT_SERIALIZER_EMPTY_MARKER_EN):
//   defined   - an all-zero vector produces one marker beat with location=0,
//               last=1, empty=1.
//   undefined - an all-zero vector is swallowed without a beat; empty is 0.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst_n     in   synchronous active-low reset
//   in_vld    in   vector valid
//   vector    in   [WIDTH-1:0] vector to serialize
//   in_rdy    out  block can accept a vector (idle and not in reset)
//   out_vld   out  beat valid
//   out_rdy   in   downstream accepts the beat
//   location  out  [15:0] index of the current set bit, zero-extended
//   last      out  current beat is the final beat of the vector
//   empty     out  current beat stands for an all-zero vector
// -----------------------------------------------------------------------------
module bit_index_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] vector,
    output logic             in_rdy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [15:0]      location,
    output logic             last,
    output logic             empty
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] work;

    logic [15:0]      hi_idx;   // index of highest set bit in work
    logic [WIDTH-1:0] hi_mask;  // one-hot mask selecting that bit
    logic             one_hot;  // work has exactly one bit set
    logic             busy;
    logic             accept;
    logic             xfer;

    // Priority encoder: scanning upward and overwriting on every set bit
    // leaves the highest one, which gives MSB-first emission.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_idx  = '0;
        hi_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (work[i]) begin
                hi_idx     = 16'(i);
                hi_mask    = '0;
                hi_mask[i] = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign one_hot = (work != '0) && ((work & (work - WIDTH'(1))) == '0);

    assign busy     = (state == BUSY);
    assign in_rdy   = rst_n && (state == IDLE);
    assign out_vld  = busy;
    assign location = busy ? hi_idx : 16'd0;

    assign accept = in_vld && in_rdy;
    assign xfer   = out_vld && out_rdy;

`ifdef BIT_SERIALIZER_EMPTY_MARKER_EN
    logic empty_q;  // BUSY holding the marker beat of an all-zero vector

    assign last  = busy && (one_hot || empty_q);
    assign empty = busy && empty_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            work    <= '0;
            empty_q <= 1'b0;
        end else if (accept) begin
            work    <= vector;
            state   <= BUSY;
            empty_q <= (vector == '0);
        end else if (xfer) begin
            if (last) begin
                state   <= IDLE;
                work    <= '0;
                empty_q <= 1'b0;
            end else begin
                work <= work & ~hi_mask;
            end
        end
    end
`else
    assign last  = busy && one_hot;
    assign empty = 1'b0;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
        end else if (accept) begin
            // An all-zero vector loads nothing useful and stays IDLE.
            work <= vector;
            if (vector != '0) begin
                state <= BUSY;
            end
        end else if (xfer) begin
            if (last) begin
                state <= IDLE;
                work  <= '0;
            end else begin
                work <= work & ~hi_mask;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bit_index_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_index_serializer
//
// Directed bench for bit_index_serializer at WIDTH=8. Inputs change 1 ns
// after the rising edge and outputs are sampled in the same window.
// -----------------------------------------------------------------------------
module tb_bit_index_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic [7:0]  vector;
    logic        in_rdy;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] location;
    logic        last;
    logic        empty;

    int checks = 0;
    int errors = 0;

    bit_index_serializer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .vector   (vector),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .location (location),
        .last     (last),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; leaves us 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a vector for exactly one accepting edge.
    task automatic send(input logic [7:0] v);
        in_vld = 1'b1;
        vector = v;
        step();
        in_vld = 1'b0;
    endtask

    // Check the beat currently on the outputs, then advance one clock.
    task automatic expect_beat(input string tag, input int loc, input logic lst, input logic emp);
        check({tag, ".vld"},   32'(out_vld),  32'd1);
        check({tag, ".loc"},   32'(location), 32'(loc));
        check({tag, ".last"},  32'(last),     32'(lst));
        check({tag, ".empty"}, 32'(empty),    32'(emp));
        check({tag, ".rdy"},   32'(in_rdy),   32'd0);
        step();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".vld"},  32'(out_vld),  32'd0);
        check({tag, ".rdy"},  32'(in_rdy),   32'd1);
        check({tag, ".loc"},  32'(location), 32'd0);
        check({tag, ".last"}, 32'(last),     32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        vector  = 8'h00;
        out_rdy = 1'b1;

        // Reset state
        step();
        step();
        check("rst.rdy",   32'(in_rdy),   32'd0);
        check("rst.vld",   32'(out_vld),  32'd0);
        check("rst.loc",   32'(location), 32'd0);
        check("rst.last",  32'(last),     32'd0);
        check("rst.empty", 32'(empty),    32'd0);
        rst_n = 1'b1;
        step();
        expect_idle("post_rst");

        // 1010_0100: beats 7,5,2 on consecutive cycles, then idle
        send(8'hA4);
        expect_beat("a4.b7", 7, 1'b0, 1'b0);
        expect_beat("a4.b5", 5, 1'b0, 1'b0);
        expect_beat("a4.b2", 2, 1'b1, 1'b0);
        expect_idle("a4.done");

        // FF with backpressure on the first beat for 3 cycles
        out_rdy = 1'b0;
        send(8'hFF);
        for (int c = 0; c < 3; c++) begin
            expect_beat($sformatf("ff.hold%0d", c), 7, 1'b0, 1'b0);
        end
        out_rdy = 1'b1;
        for (int b = 7; b >= 0; b--) begin
            expect_beat($sformatf("ff.b%0d", b), b, (b == 0), 1'b0);
        end
        expect_idle("ff.done");

        // Single-bit vectors at both ends
        send(8'h01);
        expect_beat("01.b0", 0, 1'b1, 1'b0);
        expect_idle("01.done");
        send(8'h80);
        expect_beat("80.b7", 7, 1'b1, 1'b0);
        expect_idle("80.done");

        // All-zero vector
        send(8'h00);
`ifdef BIT_SERIALIZER_EMPTY_MARKER_EN
        expect_beat("00.mark", 0, 1'b1, 1'b1);
`endif
        expect_idle("00.done");

        // Reset in the middle of F0 after the first beat
        send(8'hF0);
        expect_beat("f0.b7", 7, 1'b0, 1'b0);
        rst_n = 1'b0;
        check("f0.rst_rdy", 32'(in_rdy), 32'd0);
        step();
        check("f0.rst_vld", 32'(out_vld),  32'd0);
        check("f0.rst_loc", 32'(location), 32'd0);
        check("f0.rst_last", 32'(last),    32'd0);
        rst_n = 1'b1;
        check("f0.rel_vld", 32'(out_vld), 32'd0);
        step();
        expect_idle("f0.after");
        step();
        check("f0.quiet", 32'(out_vld), 32'd0);

        // New vectors offered while busy are ignored
        in_vld = 1'b1;
        vector = 8'hA4;
        step();
        vector = 8'hFF;
        expect_beat("busy.b7", 7, 1'b0, 1'b0);
        vector = 8'h0F;
        expect_beat("busy.b5", 5, 1'b0, 1'b0);
        vector = 8'h3C;
        in_vld = 1'b0;
        expect_beat("busy.b2", 2, 1'b1, 1'b0);
        expect_idle("busy.done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
